// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one external ALU between
// two requesters, with a fixed settle window and a tagged response.
module alu_share_arb #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [2:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [4:0]  r0_shamt,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [2:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [4:0]  r1_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_flag,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_gin,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_sum,
  input  logic [1:0]  alu_flag
);

  if (EXEC_CYCLES < 1) begin : g_bad_exec
    $error("EXEC_CYCLES must be at least 1");
  end

  localparam int CW =
    (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_rr;
  logic          r_id;

  logic          w_any;
  logic          w_gnt;
  logic          w_acc;
  logic          w_ill;
  logic          w_done;
  logic          w_hs;
  logic [2:0]    w_op;
  logic [31:0]   w_a;
  logic [31:0]   w_b;
  logic [4:0]    w_sh;

  // Grant: lone requester wins, ties go to the rr pointer.
  always_comb begin
    w_any  = r0_valid | r1_valid;
    w_gnt  = (r0_valid & r1_valid) ? r_rr : r1_valid;
    w_acc  = reset_n & (r_state == S_IDLE) & w_any;
    w_op   = w_gnt ? r1_op    : r0_op;
    w_a    = w_gnt ? r1_a     : r0_a;
    w_b    = w_gnt ? r1_b     : r0_b;
    w_sh   = w_gnt ? r1_shamt : r0_shamt;
    w_ill  = (w_op == 3'b100) | (w_op == 3'b101);
    w_done = (r_state == S_EXEC) & (r_cnt == '0);
    w_hs   = (r_state == S_RESP) & rsp_valid & rsp_ready;
  end

  assign r0_ready = w_acc & ~w_gnt;
  assign r1_ready = w_acc &  w_gnt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: illegal ops skip the ALU window entirely.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = w_ill ? S_RESP : S_EXEC;
      S_EXEC: if (w_done) w_next = S_RESP;
      S_RESP: if (w_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, rr pointer and settle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_gin   <= '0;
      alu_shamt <= '0;
      r_rr      <= 1'b0;
      r_id      <= 1'b0;
      r_cnt     <= '0;
    end else if (w_acc) begin
      alu_a     <= w_a;
      alu_b     <= w_b;
      alu_gin   <= w_op;
      alu_shamt <= w_sh;
      r_rr      <= ~w_gnt;
      r_id      <= w_gnt;
      r_cnt     <= CW'(EXEC_CYCLES - 1);
    end else if (r_state == S_EXEC && !w_done) begin
      r_cnt     <= r_cnt - CW'(1);
    end
  end

  // Response register: filled on capture or illegal accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
      rsp_err   <= 1'b0;
    end else if (w_acc && w_ill) begin
      rsp_valid <= 1'b1;
      rsp_id    <= w_gnt;
      rsp_data  <= '0;
      rsp_flag  <= 2'b01;
      rsp_err   <= 1'b1;
    end else if (w_done) begin
      rsp_valid <= 1'b1;
      rsp_id    <= r_id;
      rsp_data  <= alu_sum;
      rsp_flag  <= alu_flag;
      rsp_err   <= 1'b0;
    end else if (w_hs) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_alu_share_arb;

  localparam int EXEC_CYCLES = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [2:0]  r0_op = '0, r1_op = '0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [4:0]  r0_shamt = '0, r1_shamt = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_flag;
  logic [31:0] alu_a, alu_b, alu_sum;
  logic [2:0]  alu_gin;
  logic [4:0]  alu_shamt;
  logic [1:0]  alu_flag;

  alu_share_arb #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
    .r0_a(r0_a), .r0_b(r0_b), .r0_shamt(r0_shamt),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
    .r1_a(r1_a), .r1_b(r1_b), .r1_shamt(r1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
    .alu_shamt(alu_shamt), .alu_sum(alu_sum), .alu_flag(alu_flag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flag, sum}, flag = {sign, zero}.
  function automatic logic [33:0] alu_f(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] s;
    case (op)
      3'b010:  s = a + b;
      3'b110:  s = a - b;
      3'b111:  s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000:  s = a & b;
      3'b001:  s = a | b;
      3'b011:  s = b >> sh;
      default: s = 32'hDEAD_BEEF;
    endcase
    return {s[31], (s == 32'd0), s};
  endfunction

  assign {alu_flag, alu_sum} = alu_f(alu_gin, alu_a, alu_b, alu_shamt);

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle.
  bit          tv[2];
  logic [2:0]  top[2];
  logic [31:0] ta[2], tb_[2];
  logic [4:0]  tsh[2];
  bit          trdy;

  // Transaction model.
  bit          m_busy, m_have, m_rr, m_acc, m_acc_id;
  int          m_left;
  logic        m_rid, m_rerr, p_id;
  logic [31:0] m_rdata, p_data;
  logic [1:0]  m_rflag, p_flag;
  logic [31:0] m_aa, m_ab;
  logic [2:0]  m_agin;
  logic [4:0]  m_ash;

  task automatic model_reset();
    m_busy = 0; m_have = 0; m_rr = 0; m_acc = 0; m_left = 0;
    m_rid = 0; m_rerr = 0; m_rdata = 0; m_rflag = 0;
    m_aa = 0; m_ab = 0; m_agin = 0; m_ash = 0;
  endtask

  task automatic idle_in(input bit rdy);
    tv[0] = 0; tv[1] = 0; trdy = rdy;
  endtask

  // One cycle: starts and ends at a falling edge.
  task automatic step();
    logic [33:0] r;
    bit idle, any;
    logic g;
    chk("rsp_valid", rsp_valid, m_have);
    chk("rsp_id", rsp_id, m_rid);
    chk("rsp_data", rsp_data, m_rdata);
    chk("rsp_flag", rsp_flag, m_rflag);
    chk("rsp_err", rsp_err, m_rerr);
    chk("alu_a", alu_a, m_aa);
    chk("alu_b", alu_b, m_ab);
    chk("alu_gin", alu_gin, m_agin);
    chk("alu_shamt", alu_shamt, m_ash);
    r0_valid = tv[0]; r0_op = top[0]; r0_a = ta[0];
    r0_b = tb_[0]; r0_shamt = tsh[0];
    r1_valid = tv[1]; r1_op = top[1]; r1_a = ta[1];
    r1_b = tb_[1]; r1_shamt = tsh[1];
    rsp_ready = trdy;
    #1;
    idle = !m_busy && !m_have;
    any = tv[0] || tv[1];
    g = (tv[0] && tv[1]) ? m_rr : tv[1];
    chk("r0_ready", r0_ready, idle && any && !g);
    chk("r1_ready", r1_ready, idle && any && g);
    m_acc = 0;
    if (idle && any) begin
      m_acc = 1; m_acc_id = g;
      m_aa = ta[g]; m_ab = tb_[g]; m_agin = top[g]; m_ash = tsh[g];
      m_rr = !g;
      if (top[g] inside {3'b010, 3'b110, 3'b111,
                         3'b000, 3'b001, 3'b011}) begin
        r = alu_f(top[g], ta[g], tb_[g], tsh[g]);
        m_busy = 1; m_left = EXEC_CYCLES;
        p_id = g; p_data = r[31:0]; p_flag = r[33:32];
      end else begin
        m_have = 1; m_rid = g; m_rdata = 0;
        m_rflag = 2'b01; m_rerr = 1;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_have = 1; m_rid = p_id;
        m_rdata = p_data; m_rflag = p_flag; m_rerr = 0;
      end
    end else if (m_have && trdy) begin
      m_have = 0;
    end
    @(negedge clk);
  endtask

  // Reset applied at a falling edge, with requesters pushing.
  task automatic do_reset();
    reset_n = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flag", rsp_flag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_gin", alu_gin, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Issue one op on requester id and wait for its response.
  task automatic run_one(input bit id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
    int n;
    idle_in(0);
    tv[id] = 1; top[id] = op; ta[id] = a; tb_[id] = b; tsh[id] = sh;
    n = 0;
    do begin step(); n++; end while (!m_acc && n < 20);
    chk("acc_timeout", m_acc, 1);
    tv[id] = 0;
    n = 0;
    while (!m_have && n < 20) begin step(); n++; end
    chk("rsp_latency", n,
        (op == 3'b100 || op == 3'b101) ? 0 : EXEC_CYCLES);
  endtask

  task automatic consume();
    idle_in(1); step(); trdy = 0;
  endtask

  initial begin
    int q[$];
    for (int i = 0; i < 2; i++) begin
      top[i] = 0; ta[i] = 0; tb_[i] = 0; tsh[i] = 0;
    end
    idle_in(0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset while an op is in its settle window.
    tv[0] = 1; top[0] = 3'b010; ta[0] = 5; tb_[0] = 7;
    step();
    chk("t1_acc", m_acc, 1);
    do_reset();
    idle_in(1);
    repeat (4) step();
    run_one(1, 3'b010, 32'd1, 32'd2, 5'd0);
    chk("t1_id", rsp_id, 1);
    chk("t1_data", rsp_data, 3);
    consume();

    // Simple add.
    run_one(0, 3'b010, 32'd5, 32'd7, 5'd0);
    chk("t2_valid", rsp_valid, 1);
    chk("t2_data", rsp_data, 12);
    chk("t2_flag", rsp_flag, 2'b00);
    chk("t2_id", rsp_id, 0);
    chk("t2_err", rsp_err, 0);
    consume();

    // Both requesters continuously valid: grants alternate.
    do_reset();
    tv[0] = 1; top[0] = 3'b110; ta[0] = 3; tb_[0] = 5; tsh[0] = 0;
    tv[1] = 1; top[1] = 3'b001; ta[1] = 32'hF0; tb_[1] = 32'h0F;
    tsh[1] = 0;
    trdy = 1;
    repeat (16) begin
      if (rsp_valid && rsp_id == 0) begin
        chk("t3_r0_data", rsp_data, 32'hFFFF_FFFE);
        chk("t3_r0_flag", rsp_flag, 2'b10);
      end
      if (rsp_valid && rsp_id == 1) begin
        chk("t3_r1_data", rsp_data, 32'hFF);
        chk("t3_r1_flag", rsp_flag, 2'b00);
      end
      step();
      if (m_acc) q.push_back(int'(m_acc_id));
    end
    chk("t3_count", q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < q.size(); i++)
      chk("t3_alt", q[i], i % 2);
    idle_in(1);
    repeat (4) step();

    // Shift and set-less-than.
    run_one(1, 3'b011, 32'd0, 32'h8000_0000, 5'd31);
    chk("t4_srl", rsp_data, 1);
    consume();
    run_one(1, 3'b111, 32'd2, 32'd3, 5'd0);
    chk("t4_slt1", rsp_data, 1);
    consume();
    run_one(1, 3'b111, 32'd3, 32'd2, 5'd0);
    chk("t4_slt0", rsp_data, 0);
    chk("t4_flag", rsp_flag, 2'b01);
    consume();

    // Backpressured response blocks new grants.
    run_one(0, 3'b000, 32'hFF00, 32'h0FF0, 5'd0);
    tv[0] = 1; top[0] = 3'b010; ta[0] = 2; tb_[0] = 2;
    trdy = 0;
    repeat (10) begin
      step();
      chk("t5_hold_ready", r0_ready, 0);
      chk("t5_hold_data", rsp_data, 32'h0F00);
    end
    trdy = 1;
    step();
    chk("t5_ready_after_hs", r0_ready, 1);
    trdy = 0;
    step();
    tv[0] = 0;
    repeat (EXEC_CYCLES) step();
    chk("t5_data", rsp_data, 4);
    consume();

    // Illegal op, then a legal one.
    run_one(0, 3'b101, 32'd9, 32'd9, 5'd0);
    chk("t6_err", rsp_err, 1);
    chk("t6_data", rsp_data, 0);
    chk("t6_flag", rsp_flag, 2'b01);
    consume();
    run_one(0, 3'b000, 32'hF0F0, 32'hFF00, 5'd0);
    chk("t6_next_err", rsp_err, 0);
    chk("t6_next_data", rsp_data, 32'hF000);
    consume();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          tv[i] = ($urandom_range(0, 2) != 0);
          top[i] = 3'($urandom_range(0, 7));
          ta[i] = ($urandom_range(0, 1) != 0) ? $urandom
                                             : $urandom_range(0, 3);
          tb_[i] = ($urandom_range(0, 1) != 0) ? $urandom
                                              : $urandom_range(0, 3);
          tsh[i] = 5'($urandom_range(0, 31));
        end
        trdy = ($urandom_range(0, 9) < 7);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
